// File: rtl/sirv_debug_entry_ctrl.sv
// Debug-mode entry/exit sequencer: picks the entry cause, flushes the pipe,
// writes dpc/dcause, parks the core, and handles DRET and single-step.
module sirv_debug_entry_ctrl #(
  parameter int PC_SIZE = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmt_vld,
  input  logic [PC_SIZE-1:0] cmt_pc,
  input  logic [PC_SIZE-1:0] cmt_nxt_pc,
  input  logic               cmt_ebreak,
  input  logic               cmt_dret,
  input  logic [PC_SIZE-1:0] oldest_pc,
  input  logic               dbg_irq_r,
  input  logic               dbg_halt_r,
  input  logic               dbg_step_r,
  input  logic               dbg_ebreakm_r,
  input  logic               flush_ack,
  output logic               flush_req,
  output logic [PC_SIZE-1:0] cmt_dpc,
  output logic               cmt_dpc_ena,
  output logic [2:0]         cmt_dcause,
  output logic               cmt_dcause_ena,
  output logic               core_halted,
  output logic               step_irq_mask
);

  typedef enum logic [1:0] {RUN, FLUSH, DEBUG, STEP} state_t;

  localparam logic [2:0] CAUSE_EXIT   = 3'd0;
  localparam logic [2:0] CAUSE_EBREAK = 3'd1;
  localparam logic [2:0] CAUSE_HALT   = 3'd3;
  localparam logic [2:0] CAUSE_STEP   = 3'd4;

  state_t             state, nxt_state;
  logic               ebk_act, halt_act;
  logic               lat, entry_wr, dret_wr;
  logic [2:0]         lat_cause;
  logic [PC_SIZE-1:0] lat_pc;

  assign ebk_act  = cmt_vld & cmt_ebreak & dbg_ebreakm_r;
  assign halt_act = dbg_irq_r | dbg_halt_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    lat       = 1'b0;
    lat_cause = CAUSE_EXIT;
    lat_pc    = '0;
    entry_wr  = 1'b0;
    dret_wr   = 1'b0;
    unique case (state)
      RUN: begin
        if (ebk_act) begin
          lat = 1'b1; lat_cause = CAUSE_EBREAK; lat_pc = cmt_pc;
          nxt_state = FLUSH;
        end else if (halt_act) begin
          lat = 1'b1; lat_cause = CAUSE_HALT; lat_pc = oldest_pc;
          nxt_state = FLUSH;
        end
      end
      FLUSH: begin
        if (flush_ack) begin
          entry_wr  = 1'b1;
          nxt_state = DEBUG;
        end
      end
      DEBUG: begin
        if (cmt_dret) begin
          dret_wr   = 1'b1;
          nxt_state = dbg_step_r ? STEP : RUN;
        end
      end
      STEP: begin
        // Haltreq is deliberately not looked at: the stepped instruction must retire first.
        if (cmt_vld) begin
          lat = 1'b1;
          if (ebk_act) begin lat_cause = CAUSE_EBREAK; lat_pc = cmt_pc;     end
          else         begin lat_cause = CAUSE_STEP;   lat_pc = cmt_nxt_pc; end
          nxt_state = FLUSH;
        end
      end
      default: nxt_state = RUN;
    endcase
  end

  always_comb begin
    flush_req     = (state == FLUSH);
    core_halted   = (state == DEBUG);
    step_irq_mask = (state == STEP);
  end

  // cmt_dpc/cmt_dcause double as the latch for the pending entry; the
  // write pulses are registered so nothing here follows flush_ack combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmt_dpc        <= '0;
      cmt_dcause     <= CAUSE_EXIT;
      cmt_dpc_ena    <= 1'b0;
      cmt_dcause_ena <= 1'b0;
    end else begin
      cmt_dpc_ena    <= entry_wr;
      cmt_dcause_ena <= entry_wr | dret_wr;
      if (lat) begin
        cmt_dpc    <= lat_pc & ~{{(PC_SIZE-1){1'b0}}, 1'b1};
        cmt_dcause <= lat_cause;
      end else if (dret_wr) begin
        cmt_dcause <= CAUSE_EXIT;
      end
    end
  end

endmodule

// File: tb/tb_sirv_debug_entry_ctrl.sv
// Directed vector table plus hand sequences for sirv_debug_entry_ctrl.
module tb_sirv_debug_entry_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cmt_vld = 0, cmt_ebreak = 0, cmt_dret = 0;
  logic [31:0] cmt_pc = '0, cmt_nxt_pc = '0, oldest_pc = '0;
  logic        dbg_irq_r = 0, dbg_halt_r = 0, dbg_step_r = 0, dbg_ebreakm_r = 0, flush_ack = 0;
  logic        flush_req, cmt_dpc_ena, cmt_dcause_ena, core_halted, step_irq_mask;
  logic [31:0] cmt_dpc;
  logic [2:0]  cmt_dcause;

  sirv_debug_entry_ctrl #(.PC_SIZE(32)) dut (
    .clk(clk), .rst_n(rst_n), .cmt_vld(cmt_vld), .cmt_pc(cmt_pc), .cmt_nxt_pc(cmt_nxt_pc),
    .cmt_ebreak(cmt_ebreak), .cmt_dret(cmt_dret), .oldest_pc(oldest_pc),
    .dbg_irq_r(dbg_irq_r), .dbg_halt_r(dbg_halt_r), .dbg_step_r(dbg_step_r),
    .dbg_ebreakm_r(dbg_ebreakm_r), .flush_ack(flush_ack), .flush_req(flush_req),
    .cmt_dpc(cmt_dpc), .cmt_dpc_ena(cmt_dpc_ena), .cmt_dcause(cmt_dcause),
    .cmt_dcause_ena(cmt_dcause_ena), .core_halted(core_halted), .step_irq_mask(step_irq_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, vld, ebk, dret, irq, hlt, stp, ebm, ack;
    logic [31:0] pc, npc, opc;
    logic fr, de, ce, hl, mk;
    logic [31:0] dpc;
    logic [2:0]  dc;
  } vec_t;

  vec_t tbl[$];
  int n_chk = 0, n_fail = 0;

  task automatic add(input logic rst, vld, ebk, dret, irq, hlt, stp, ebm, ack,
                     input logic [31:0] pc, npc, opc,
                     input logic fr, de, ce, hl, mk,
                     input logic [31:0] dpc, input logic [2:0] dc);
    vec_t v;
    v.rst = rst; v.vld = vld; v.ebk = ebk; v.dret = dret; v.irq = irq; v.hlt = hlt;
    v.stp = stp; v.ebm = ebm; v.ack = ack; v.pc = pc; v.npc = npc; v.opc = opc;
    v.fr = fr; v.de = de; v.ce = ce; v.hl = hl; v.mk = mk; v.dpc = dpc; v.dc = dc;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_n = v.rst; cmt_vld = v.vld; cmt_ebreak = v.ebk; cmt_dret = v.dret;
    dbg_irq_r = v.irq; dbg_halt_r = v.hlt; dbg_step_r = v.stp; dbg_ebreakm_r = v.ebm;
    flush_ack = v.ack; cmt_pc = v.pc; cmt_nxt_pc = v.npc; oldest_pc = v.opc;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  int lat;

  initial begin
    //  rst vld ebk drt irq hlt stp ebm ack  pc           npc          opc          fr de ce hl mk dpc          dc
    // reset, with an ebreak presented that must be ignored
    add(0,1,1,0,1,0,0,1,0, 32'h10,       32'h14,       32'h10,       0,0,0,0,0, 32'h0,        0);
    add(0,0,0,0,0,0,0,1,0, 32'h0,        32'h0,        32'h0,        0,0,0,0,0, 32'h0,        0);
    // ebreak entry, ack tied high: write 2 cycles after cause
    add(1,1,1,0,0,0,0,1,1, 32'h80000104, 32'h80000108, 32'h80000104, 1,0,0,0,0, 32'h0,        0);
    add(1,0,0,0,0,0,0,1,1, 32'h0,        32'h0,        32'h0,        0,1,1,1,0, 32'h80000104, 1);
    add(1,0,0,0,0,0,0,1,1, 32'h0,        32'h0,        32'h0,        0,0,0,1,0, 32'h0,        0);
    add(1,1,1,0,1,1,0,1,1, 32'h50,       32'h54,       32'h50,       0,0,0,1,0, 32'h0,        0);
    add(1,0,0,1,0,0,0,1,0, 32'h0,        32'h0,        32'h0,        0,0,1,0,0, 32'h0,        0);
    add(1,0,0,1,0,0,0,1,0, 32'h0,        32'h0,        32'h0,        0,0,0,0,0, 32'h0,        0);
    // haltreq, ack delayed 5 cycles: flush_req seen 6 cycles
    add(1,0,0,0,1,0,0,1,0, 32'h999,      32'h99d,      32'h200,      1,0,0,0,0, 32'h0,        0);
    add(1,0,0,0,1,0,0,1,0, 32'h999,      32'h99d,      32'h200,      1,0,0,0,0, 32'h0,        0);
    add(1,0,0,0,1,0,0,1,0, 32'h999,      32'h99d,      32'h200,      1,0,0,0,0, 32'h0,        0);
    add(1,0,0,0,1,0,0,1,0, 32'h999,      32'h99d,      32'h200,      1,0,0,0,0, 32'h0,        0);
    add(1,0,0,0,1,0,0,1,0, 32'h999,      32'h99d,      32'h200,      1,0,0,0,0, 32'h0,        0);
    add(1,0,0,0,1,0,0,1,0, 32'h999,      32'h99d,      32'h200,      1,0,0,0,0, 32'h0,        0);
    add(1,0,0,0,1,0,0,1,1, 32'h999,      32'h99d,      32'h300,      0,1,1,1,0, 32'h200,      3);
    add(1,0,0,1,0,0,0,1,0, 32'h0,        32'h0,        32'h0,        0,0,1,0,0, 32'h0,        0);
    // ebreak + haltreq together: ebreak wins, dpc bit0 cleared
    add(1,1,1,0,1,0,0,1,1, 32'h1235,     32'h1239,     32'h500,      1,0,0,0,0, 32'h0,        0);
    add(1,0,0,0,0,0,0,1,1, 32'h0,        32'h0,        32'h0,        0,1,1,1,0, 32'h1234,     1);
    // single step: dret -> STEP, haltreq ignored, commit -> cause 4
    add(1,0,0,1,0,0,1,1,0, 32'h0,        32'h0,        32'h0,        0,0,1,0,1, 32'h0,        0);
    add(1,0,0,0,1,1,1,1,0, 32'h0,        32'h0,        32'h0,        0,0,0,0,1, 32'h0,        0);
    add(1,1,0,0,0,0,1,1,0, 32'h300,      32'h304,      32'h300,      1,0,0,0,0, 32'h0,        0);
    add(1,0,0,0,0,0,1,1,1, 32'h0,        32'h0,        32'h0,        0,1,1,1,0, 32'h304,      4);
    // step over an armed ebreak -> cause 1
    add(1,0,0,1,0,0,1,1,0, 32'h0,        32'h0,        32'h0,        0,0,1,0,1, 32'h0,        0);
    add(1,1,1,0,0,0,1,1,0, 32'h400,      32'h404,      32'h400,      1,0,0,0,0, 32'h0,        0);
    add(1,0,0,0,0,0,0,1,1, 32'h0,        32'h0,        32'h0,        0,1,1,1,0, 32'h400,      1);
    add(1,0,0,1,0,0,0,1,0, 32'h0,        32'h0,        32'h0,        0,0,1,0,0, 32'h0,        0);
    // unarmed ebreak
    add(1,1,1,0,0,0,0,0,0, 32'h600,      32'h604,      32'h600,      0,0,0,0,0, 32'h0,        0);
    add(1,0,0,0,0,0,0,0,0, 32'h0,        32'h0,        32'h0,        0,0,0,0,0, 32'h0,        0);
    // dcsr.halt entry, reset mid-FLUSH with ack present
    add(1,0,0,0,0,1,0,1,0, 32'h0,        32'h0,        32'h40,       1,0,0,0,0, 32'h0,        0);
    add(1,0,0,0,0,0,0,1,0, 32'h0,        32'h0,        32'h0,        1,0,0,0,0, 32'h0,        0);
    add(0,0,0,0,0,0,0,1,1, 32'h0,        32'h0,        32'h0,        0,0,0,0,0, 32'h0,        0);
    add(1,0,0,0,0,0,0,1,1, 32'h0,        32'h0,        32'h0,        0,0,0,0,0, 32'h0,        0);

    foreach (tbl[i]) begin
      drive(tbl[i]);
      tick();
      chk($sformatf("v%0d flush_req", i),      32'(flush_req),      32'(tbl[i].fr));
      chk($sformatf("v%0d dpc_ena", i),        32'(cmt_dpc_ena),    32'(tbl[i].de));
      chk($sformatf("v%0d dcause_ena", i),     32'(cmt_dcause_ena), 32'(tbl[i].ce));
      chk($sformatf("v%0d core_halted", i),    32'(core_halted),    32'(tbl[i].hl));
      chk($sformatf("v%0d step_irq_mask", i),  32'(step_irq_mask),  32'(tbl[i].mk));
      if (tbl[i].de || !tbl[i].rst)
        chk($sformatf("v%0d dpc", i), cmt_dpc, tbl[i].dpc);
      if (tbl[i].de || tbl[i].ce || !tbl[i].rst)
        chk($sformatf("v%0d dcause", i), 32'(cmt_dcause), 32'(tbl[i].dc));
    end

    // entry latency measured with a bounded wait
    cmt_vld = 1; cmt_ebreak = 1; dbg_ebreakm_r = 1; cmt_pc = 32'h700; flush_ack = 1;
    tick();
    cmt_vld = 0; cmt_ebreak = 0;
    lat = 1;
    while (!cmt_dpc_ena && lat < 8) begin
      tick();
      lat++;
    end
    chk("seq entry_latency", 32'(lat), 32'd2);
    chk("seq entry_dpc", cmt_dpc, 32'h700);
    tick();
    chk("seq pulse_one_cycle", 32'(cmt_dpc_ena), 32'd0);
    chk("seq halted_held", 32'(core_halted), 32'd1);
    cmt_dret = 1; dbg_step_r = 0;
    tick();
    cmt_dret = 0;
    chk("seq dret_to_run", 32'(core_halted), 32'd0);

    // reset mid-STEP abandons the step
    dbg_halt_r = 1;
    tick();
    dbg_halt_r = 0;
    tick();
    chk("seq halt_entry", 32'(core_halted), 32'd1);
    cmt_dret = 1; dbg_step_r = 1;
    tick();
    cmt_dret = 0;
    chk("seq step_mask", 32'(step_irq_mask), 32'd1);
    rst_n = 0;
    #1;
    chk("seq rst_mask", 32'(step_irq_mask), 32'd0);
    chk("seq rst_dcause_ena", 32'(cmt_dcause_ena), 32'd0);
    tick();
    rst_n = 1; cmt_vld = 1; cmt_pc = 32'h800; cmt_nxt_pc = 32'h804;
    tick();
    cmt_vld = 0;
    chk("seq run_after_rst", 32'(flush_req), 32'd0);
    chk("seq no_ena_after_rst", 32'(cmt_dpc_ena | cmt_dcause_ena), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sirv_debug_entry_ctrl.md
SIRV_DEBUG_ENTRY_CTRL -- requirements
Module: sirv_debug_entry_ctrl

Interface
REQ-001 SHALL have parameter PC_SIZE, default 32, giving the PC width.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port cmt_vld, input, 1: one instruction commits this cycle.
REQ-005 SHALL have port cmt_pc, input, PC_SIZE: PC of the committing instruction.
REQ-006 SHALL have port cmt_nxt_pc, input, PC_SIZE: PC of the instruction after the committing one.
REQ-007 SHALL have port cmt_ebreak, input, 1: the committing instruction is EBREAK; meaningful only with cmt_vld.
REQ-008 SHALL have port cmt_dret, input, 1: a DRET commits this cycle.
REQ-009 SHALL have port oldest_pc, input, PC_SIZE: PC of the oldest uncommitted instruction.
REQ-010 SHALL have port dbg_irq_r, input, 1: halt request from the debug module.
REQ-011 SHALL have ports dbg_halt_r, dbg_step_r, dbg_ebreakm_r, input, 1 each: the dcsr halt, step and ebreakm bits.
REQ-012 SHALL have port flush_ack, input, 1: the pipeline has been flushed.
REQ-013 SHALL have port flush_req, output, 1: request a pipeline flush.
REQ-014 SHALL have port cmt_dpc, output, PC_SIZE, and port cmt_dpc_ena, output, 1: the dpc write.
REQ-015 SHALL have port cmt_dcause, output, 3, and port cmt_dcause_ena, output, 1: the dcause write.
REQ-016 SHALL have port core_halted, output, 1: the core is parked in debug mode.
REQ-017 SHALL have port step_irq_mask, output, 1: mask interrupts while a single step is in flight.

Function
REQ-018 SHALL implement FSM states RUN, FLUSH, DEBUG and STEP.
REQ-019 SHALL, in RUN, evaluate debug-entry causes in priority order ebreak(1) > haltreq(3).
REQ-020 SHALL treat ebreak as active when cmt_vld & cmt_ebreak & dbg_ebreakm_r, latching cause 3'd1 and dpc=cmt_pc.
REQ-021 SHALL treat haltreq as active when (dbg_irq_r | dbg_halt_r) and no ebreak cause is active, latching cause 3'd3 and dpc=oldest_pc.
REQ-022 SHALL move from RUN to FLUSH on the cycle after any active cause.
REQ-023 SHALL, in FLUSH, hold flush_req=1 (registered) every cycle until flush_ack=1.
REQ-024 SHALL, on the FLUSH cycle with flush_ack=1, pulse cmt_dpc_ena=1 and cmt_dcause_ena=1 for one cycle, driving the latched dpc (bit0 forced to 0) and cause, and enter DEBUG on the next edge.
REQ-025 SHALL, in FLUSH and DEBUG, ignore cmt_vld, cmt_ebreak, dbg_irq_r and dbg_halt_r.
REQ-026 SHALL drive core_halted=1 exactly while the state is DEBUG.
REQ-027 SHALL, in DEBUG on cmt_dret=1, pulse cmt_dcause_ena=1 with cmt_dcause=3'd0 (exit) for one cycle.
REQ-028 SHALL, on that DRET, go to STEP if dbg_step_r=1, else to RUN.
REQ-029 SHALL ignore cmt_dret outside DEBUG.
REQ-030 SHALL drive step_irq_mask=1 exactly while the state is STEP.
REQ-031 SHALL, in STEP, ignore haltreq and wait for exactly one cmt_vld.
REQ-032 SHALL, on that commit, latch cause 1 and dpc=cmt_pc if the ebreak condition holds, else cause 3'd4 and dpc=cmt_nxt_pc, then go to FLUSH.
REQ-033 SHALL drive cmt_dpc_ena and cmt_dcause_ena low on every cycle not named in REQ-024 and REQ-027; the two are never simultaneous.
REQ-034 SHALL make entry latency 2 cycles from cause to dpc/dcause write when flush_ack is already high on the first FLUSH cycle; each cycle of ack delay adds one cycle.
REQ-035 SHALL drive all outputs from registers or from state decode only, with no combinational path from an input to flush_req.

Reset
REQ-036 SHALL, while rst_n=0, force state=RUN, flush_req=0, cmt_dpc_ena=0, cmt_dcause_ena=0, core_halted=0, step_irq_mask=0, cmt_dpc=0 and cmt_dcause=0.
REQ-037 SHALL, on reset assertion mid-FLUSH or mid-STEP, abandon the sequence with no dpc or dcause write, and return to RUN after release.

Verification
REQ-038 SHALL cover ebreak entry: dbg_ebreakm_r=1, cmt_vld+cmt_ebreak, cmt_pc=0x80000104, flush_ack tied 1 -> 2 cycles later cmt_dpc=0x80000104 and cmt_dcause=1 pulse, then core_halted=1.
REQ-039 SHALL cover haltreq with slow ack: dbg_irq_r=1, oldest_pc=0x200, flush_ack delayed 5 cycles -> flush_req high for 6 cycles, then dpc=0x200 and cause=3.
REQ-040 SHALL cover the simultaneous-cause case: ebreak and dbg_irq_r in the same cycle -> cause=1 and dpc=cmt_pc.
REQ-041 SHALL cover single step: in DEBUG with dbg_step_r=1, cmt_dret -> dcause=0 pulse, then STEP with step_irq_mask=1; one commit with cmt_nxt_pc=0x304 -> dpc=0x304 and cause=4.
REQ-042 SHALL cover an unarmed ebreak: dbg_ebreakm_r=0 with ebreak commit -> no flush_req and state stays RUN.
REQ-043 SHALL cover reset mid-FLUSH: rst_n pulsed low in FLUSH -> no ena pulses and all outputs 0 after release.
